// File: rtl/apb_regfile_slave.sv
// APB register-file slave with byte strobes, wait states,
// read-only status registers and PSLVERR on bad accesses.
module apb_regfile_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'('h80),
  parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic [ADDR_W-1:0]          paddr_i,
  input  logic                       pwrite_i,
  input  logic [DATA_W-1:0]          pwdata_i,
  input  logic [DATA_W/8-1:0]        pstrb_i,
  output logic [DATA_W-1:0]          prdata_o,
  output logic                       pready_o,
  output logic                       pslverr_o,
  input  logic [NUM_REGS*DATA_W-1:0] ro_data_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NB    = DATA_W / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic              oor_q;
  logic              err_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [IDX_W-1:0]  idx_d;
  logic              oor_d;
  logic              setup;
  logic              done;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr;

  assign idx_d       = paddr_i[IDX_W+1:2];
  assign oor_d       = |paddr_i[ADDR_W-1:IDX_W+2];
  assign unused_addr = ^paddr_i[1:0];
  assign setup       = psel_i & ~penable_i;
  assign pready_o    = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign done        = pready_o & psel_i & penable_i;
  assign wr_en       = done & wr_q & ~err_q;
  assign pslverr_o   = pready_o & err_q;

  // Transfer sequencing: latch the request at setup, count wait states
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (setup) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(WAIT_CYCLES);
            idx_q   <= idx_d;
            wr_q    <= pwrite_i;
            oor_q   <= oor_d;
            err_q   <= oor_d | (pwrite_i & RO_MASK[idx_d]);
          end
        end
        ACCESS: begin
          if (!psel_i || done)
            state_q <= IDLE;
          else if (cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
        end
      endcase
    end
  end

  // Register storage: commit strobed byte lanes on a clean write
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= RST_VAL;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (pstrb_i[b])
          regs_q[idx_q][b*8 +: 8] <= pwdata_i[b*8 +: 8];
    end
  end

  // Read data: status slice for RO regs, storage otherwise
  always_comb begin
    rd_word = regs_q[idx_q];
    if (RO_MASK[idx_q])
      rd_word = ro_data_i[int'(idx_q)*DATA_W +: DATA_W];
  end

  assign prdata_o = (pready_o && !oor_q) ? rd_word : '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave
// with hand-computed expected values.
module tb_apb_regfile_slave;

  logic         pclk = 1'b0;
  logic         preset_n;
  logic         psel, penable, pwrite;
  logic [31:0]  paddr, pwdata, prdata;
  logic [3:0]   pstrb;
  logic         pready, pslverr;
  logic [255:0] ro_data, regs;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        err;
  int          waits;

  always #5 pclk = ~pclk;

  apb_regfile_slave dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .psel_i    (psel),
    .penable_i (penable),
    .paddr_i   (paddr),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .pstrb_i   (pstrb),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .ro_data_i (ro_data),
    .regs_o    (regs)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int i);
    return regs[i*32 +: 32];
  endfunction

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    bit got;
    psel = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; got = 1'b0; rd = 'x; err = 1'b x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge pclk);
      if (pready) begin
        rd = prdata; err = pslverr; got = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL timeout addr=%h observed=no pready required=pready", a);
    end
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    preset_n = 1'b0;
    psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0;
    ro_data = '0;
    ro_data[7*32 +: 32] = 32'h0000A5A5;
    #12;
    chk("rst_pready", {31'b0, pready}, 32'd0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    @(posedge pclk); #1;
    preset_n = 1'b1;
    @(posedge pclk); #1;
    for (int i = 0; i < 8; i++)
      chk($sformatf("rst_reg%0d", i), slice(i), 32'd0);

    xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    chk("wr1_waits", 32'(waits), 32'd1);
    chk("wr1_err", {31'b0, err}, 32'd0);
    chk("wr1_reg1", slice(1), 32'hDEADBEEF);
    idle(1);
    xfer(1'b0, 32'h04, 32'h0, 4'h0);
    chk("rd1_data", rd, 32'hDEADBEEF);
    chk("rd1_err", {31'b0, err}, 32'd0);
    idle(1);

    xfer(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF);
    idle(1);
    xfer(1'b1, 32'h08, 32'h11223344, 4'b0101);
    chk("strb_reg2", slice(2), 32'hFF22FF44);
    idle(1);

    xfer(1'b1, 32'h1C, 32'h1, 4'hF);
    chk("ro_wr_err", {31'b0, err}, 32'd1);
    chk("ro_wr_reg7", slice(7), 32'd0);
    idle(1);
    xfer(1'b0, 32'h1C, 32'h0, 4'h0);
    chk("ro_rd_data", rd, 32'h0000A5A5);
    chk("ro_rd_err", {31'b0, err}, 32'd0);
    idle(1);

    xfer(1'b0, 32'h40, 32'h0, 4'h0);
    chk("oor_rd_err", {31'b0, err}, 32'd1);
    chk("oor_rd_data", rd, 32'd0);
    idle(1);
    xfer(1'b1, 32'h40, 32'h55555555, 4'hF);
    chk("oor_wr_err", {31'b0, err}, 32'd1);
    chk("oor_wr_reg0", slice(0), 32'd0);
    idle(1);

    xfer(1'b1, 32'h04, 32'h0, 4'h0);
    chk("strb0_err", {31'b0, err}, 32'd0);
    chk("strb0_reg1", slice(1), 32'hDEADBEEF);

    xfer(1'b1, 32'h0C, 32'h12345678, 4'hF);
    xfer(1'b0, 32'h0F, 32'h0, 4'h0);
    chk("b2b_rd", rd, 32'h12345678);
    chk("b2b_reg3", slice(3), 32'h12345678);
    idle(1);

    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 32'h18; pwdata = 32'h77; pstrb = 4'hF;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("nosetup_pready", {31'b0, pready}, 32'd0);
    chk("nosetup_reg6", slice(6), 32'd0);
    idle(1);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'hCAFE; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(negedge pclk);
    chk("abort_pready", {31'b0, pready}, 32'd0);
    chk("abort_reg4", slice(4), 32'd0);
    @(posedge pclk); #1;
    xfer(1'b1, 32'h10, 32'hCAFE, 4'hF);
    chk("post_abort_reg4", slice(4), 32'h0000CAFE);
    chk("post_abort_waits", 32'(waits), 32'd1);
    idle(1);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h14; pwdata = 32'hBEEF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    preset_n = 1'b0;
    #1;
    chk("midrst_pready", {31'b0, pready}, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);
    chk("midrst_reg5", slice(5), 32'd0);
    chk("midrst_reg1", slice(1), 32'd0);
    chk("midrst_pready2", {31'b0, pready}, 32'd0);
    @(posedge pclk); #1;
    xfer(1'b1, 32'h14, 32'hBEEF, 4'hF);
    chk("post_rst_reg5", slice(5), 32'h0000BEEF);
    xfer(1'b0, 32'h14, 32'h0, 4'h0);
    chk("post_rst_rd", rd, 32'h0000BEEF);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
